// File: rtl/us_pkg.sv
// ---------------------------------------------------------------------------
// us_pkg
// Shared definitions for the ultrasonic ranging front end.
//   - us_state_t : measurement sequencer states
//   - *_DEF      : default cycle constants for a 100 MHz clock
// No ports (package).
// ---------------------------------------------------------------------------
package us_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    HOLDOFF
  } us_state_t;

  localparam int TRIG_CYC_DEF     = 1000;     // 10 us trigger pulse
  localparam int CM_CYC_DEF       = 5800;     // 58 us of round trip per cm
  localparam int WAIT_CYC_DEF     = 2500000;  // 25 ms to see the echo rise
  localparam int ECHO_MAX_CYC_DEF = 3000000;  // 30 ms longest valid echo
  localparam int PERIOD_CYC_DEF   = 6000000;  // 60 ms trigger-to-trigger
  localparam int CNT_W_DEF        = 23;       // holds the largest constant

endpackage

// File: rtl/us_sync_edge.sv
// ---------------------------------------------------------------------------
// us_sync_edge
// Two-flop synchroniser for an asynchronous level input, followed by a third
// flop used purely for edge detection. Reusable for any slow sensor input.
// Ports:
//   clk   in   system clock
//   reset in   asynchronous, active-high
//   din   in   raw asynchronous input
//   sync  out  synchronised level (second flop)
//   rise  out  one-clk pulse, sync went 0->1 on the last edge
//   fall  out  one-clk pulse, sync went 1->0 on the last edge
// ---------------------------------------------------------------------------
module us_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic dly_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      dly_reg  <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      dly_reg  <= sync_reg;
    end
  end

  assign sync = sync_reg;
  assign rise = sync_reg & ~dly_reg;
  assign fall = ~sync_reg & dly_reg;

endmodule

// File: rtl/us_echo_sequencer.sv
// ---------------------------------------------------------------------------
// us_echo_sequencer
// Fires the HC-SR04 trigger, times the returning echo and feeds the BCD
// distance counter with an enable window plus one strobe per centimetre.
// Enforces an echo-rise timeout, a maximum echo length and a minimum
// trigger-to-trigger period. Single-shot (start) or free-running (auto).
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high (released synchronously inside)
//   start    in   single-shot request, honoured only in IDLE
//   auto     in   1 = re-trigger automatically after HOLDOFF
//   echo     in   raw sensor echo, asynchronous to clk
//   trig     out  sensor trigger, registered
//   meas_ena out  counter enable, high while the echo is being timed
//   cm_tick  out  one-clk strobe per CM_CYC cycles of meas_ena
//   busy     out  high in every state except IDLE
//   done     out  one-clk pulse on a normal end of measurement
//   timeout  out  one-clk pulse on echo-rise or echo-length timeout
// ---------------------------------------------------------------------------
module us_echo_sequencer
  import us_pkg::*;
#(
  parameter int TRIG_CYC     = TRIG_CYC_DEF,
  parameter int CM_CYC       = CM_CYC_DEF,
  parameter int WAIT_CYC     = WAIT_CYC_DEF,
  parameter int ECHO_MAX_CYC = ECHO_MAX_CYC_DEF,
  parameter int PERIOD_CYC   = PERIOD_CYC_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic auto,
  input  logic echo,
  output logic trig,
  output logic meas_ena,
  output logic cm_tick,
  output logic busy,
  output logic done,
  output logic timeout
);

  // Last count value of each interval; a counter sitting on *_LAST means the
  // interval ends on the coming edge.
  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] CM_LAST     = CNT_W'(CM_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST   = CNT_W'(ECHO_MAX_CYC - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Reset: asserted asynchronously, released on a clock edge so no flop sees
  // the release near its sampling window.
  logic [1:0] rst_pipe_reg;
  logic       rst_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_pipe_reg <= 2'b11;
    end else begin
      rst_pipe_reg <= {rst_pipe_reg[0], 1'b0};
    end
  end

  assign rst_int = rst_pipe_reg[1];

  logic echo_s;
  logic echo_rise;
  logic echo_fall;

  us_sync_edge u_echo_sync (
    .clk   (clk),
    .reset (rst_int),
    .din   (echo),
    .sync  (echo_s),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  us_state_t        state_reg;
  logic [CNT_W-1:0] state_cnt_reg;   // cycles spent in the current state
  logic [CNT_W-1:0] period_cnt_reg;  // cycles since the last trigger rise
  logic [CNT_W-1:0] tick_cnt_reg;    // position inside the current cm

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_reg      <= IDLE;
      state_cnt_reg  <= '0;
      period_cnt_reg <= '0;
      tick_cnt_reg   <= '0;
      trig           <= 1'b0;
      meas_ena       <= 1'b0;
      cm_tick        <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      cm_tick <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;

      // Free-running; parks on PERIOD_LAST, which is all HOLDOFF needs.
      if (period_cnt_reg < PERIOD_LAST) begin
        period_cnt_reg <= period_cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (start || auto) begin
            state_reg      <= TRIG;
            trig           <= 1'b1;
            state_cnt_reg  <= '0;
            period_cnt_reg <= '0;
          end
        end

        TRIG: begin
          if (state_cnt_reg >= TRIG_LAST) begin
            state_reg     <= WAIT_ECHO;
            trig          <= 1'b0;
            state_cnt_reg <= '0;
          end else begin
            state_cnt_reg <= sat_inc(state_cnt_reg);
          end
        end

        // Only a genuine rise counts: an echo already high on entry has no
        // rise pulse and must go low first.
        WAIT_ECHO: begin
          if (echo_rise) begin
            state_reg     <= MEASURE;
            meas_ena      <= 1'b1;
            state_cnt_reg <= '0;
            tick_cnt_reg  <= '0;
          end else if (state_cnt_reg >= WAIT_LAST) begin
            state_reg <= HOLDOFF;
            timeout   <= 1'b1;
          end else begin
            state_cnt_reg <= sat_inc(state_cnt_reg);
          end
        end

        // Echo fall wins over the length limit so done and timeout never
        // coincide. No tick is issued on the exit edge: a tick only lands in
        // a cycle where meas_ena is still high, so a partial cm is dropped.
        MEASURE: begin
          if (echo_fall) begin
            state_reg <= HOLDOFF;
            meas_ena  <= 1'b0;
            done      <= 1'b1;
          end else if (state_cnt_reg >= ECHO_LAST) begin
            state_reg <= HOLDOFF;
            meas_ena  <= 1'b0;
            timeout   <= 1'b1;
          end else begin
            meas_ena      <= echo_s;
            state_cnt_reg <= sat_inc(state_cnt_reg);
            if (tick_cnt_reg >= CM_LAST) begin
              tick_cnt_reg <= '0;
              cm_tick      <= 1'b1;
            end else begin
              tick_cnt_reg <= sat_inc(tick_cnt_reg);
            end
          end
        end

        // Leave only once the full period has elapsed and the sensor has
        // released its echo line, so a late echo never bleeds into the next
        // measurement.
        HOLDOFF: begin
          if ((period_cnt_reg >= PERIOD_LAST) && !echo_s) begin
            if (auto) begin
              state_reg      <= TRIG;
              trig           <= 1'b1;
              state_cnt_reg  <= '0;
              period_cnt_reg <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          trig      <= 1'b0;
          meas_ena  <= 1'b0;
        end
      endcase
    end
  end

endmodule
